ser_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one framed serial link between NUM_REQ parallel requesters. It grants one requester at a time and latches its word. It then shifts the word out MSB-first, asserting lsb_out on the final bit, which is the framing the Ser2Par receiver expects. It sits on the transmit side of the link and drives Ser2Par's serial_in and lsb_in directly.

---
 rtl/ser_link_pkg.sv | 21 ++
 rtl/ser_tx_arbiter_rr_pick.sv | 34 +++
 rtl/ser_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_ser_tx_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ser_link_pkg.sv
// Shared definitions for the framed serial link: FSM states, default word size
// and a width helper.
package ser_link_pkg;

  localparam int DEF_WORD_SIZE = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } link_state_t;

  // Minimum width of 1 so single-value counters and indices stay legal vectors.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ser_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: the first set req strictly after ptr,
// wrapping around, wins.
module rr_pick
  import ser_link_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [ID_W-1:0]    win_idx,
  output logic               any_req
);

  logic [ID_W-1:0] j;

  // Scan from the farthest offset down so the nearest candidate overwrites last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any_req = |req;
    j       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        win_oh    = '0;
        win_oh[j] = 1'b1;
        win_idx   = j;
      end
    end
  end

endmodule

// File: rtl/ser_tx_arbiter.sv
// Round-robin arbiter that serialises one requester's word at a time, MSB first,
// with lsb_out marking the final bit of each word.
module ser_tx_arbiter
  import ser_link_pkg::*;
#(
  parameter  int WORD_SIZE = DEF_WORD_SIZE,
  parameter  int NUM_REQ   = 4,
  parameter  int GAP       = 0,
  localparam int ID_W      = clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WORD_SIZE-1:0] data,
  input  logic                         pause,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         serial_out,
  output logic                         lsb_out,
  output logic                         active,
  output logic [ID_W-1:0]              grant_id
);

  localparam int BC_W = clog2(WORD_SIZE);
  localparam int GC_W = clog2(GAP + 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_SIZE - 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP > 0) ? GAP - 1 : 0);

  if (WORD_SIZE < 2) begin : g_bad_word
    $error("ser_tx_arbiter: WORD_SIZE must be >= 2");
  end
  if (NUM_REQ < 2) begin : g_bad_req
    $error("ser_tx_arbiter: NUM_REQ must be >= 2");
  end

  link_state_t          state;
  logic [BC_W-1:0]      bit_cnt;
  logic [GC_W-1:0]      gap_cnt;
  logic [WORD_SIZE-1:0] shreg;
  logic [ID_W-1:0]      last_grant;

  logic [NUM_REQ-1:0]   win_oh;
  logic [ID_W-1:0]      win_idx;
  logic                 any_req;
  logic                 sample_pt;
  logic                 grant;
  logic [WORD_SIZE-1:0] win_word;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (last_grant),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    case (state)
      ST_IDLE:  sample_pt = 1'b1;
      ST_SHIFT: sample_pt = (GAP == 0) && (bit_cnt == BIT_LAST);
      ST_GAP:   sample_pt = (gap_cnt == GAP_LAST);
      default:  sample_pt = 1'b1;
    endcase
  end

  assign grant    = sample_pt && !pause && any_req;
  assign win_word = data[int'(win_idx)*WORD_SIZE +: WORD_SIZE];

  // serial_out is a registered copy of shreg's MSB, so each shift forwards
  // the bit below the current MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      ack        <= '0;
      serial_out <= 1'b0;
      lsb_out    <= 1'b0;
      active     <= 1'b0;
      grant_id   <= '0;
    end else begin
      ack <= '0;
      if (grant) begin
        state      <= ST_SHIFT;
        bit_cnt    <= '0;
        gap_cnt    <= '0;
        shreg      <= win_word;
        last_grant <= win_idx;
        ack        <= win_oh;
        serial_out <= win_word[WORD_SIZE-1];
        lsb_out    <= 1'b0;
        active     <= 1'b1;
        grant_id   <= win_idx;
      end else begin
        case (state)
          ST_SHIFT: begin
            if (bit_cnt != BIT_LAST) begin
              bit_cnt    <= bit_cnt + 1'b1;
              shreg      <= shreg << 1;
              serial_out <= shreg[WORD_SIZE-2];
              lsb_out    <= ((bit_cnt + 1'b1) == BIT_LAST);
            end else begin
              state      <= (GAP > 0) ? ST_GAP : ST_IDLE;
              gap_cnt    <= '0;
              serial_out <= 1'b0;
              lsb_out    <= 1'b0;
              active     <= 1'b0;
              grant_id   <= '0;
            end
          end
          ST_GAP: begin
            if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
            else                     state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ser_tx_arbiter.sv
// Randomised bench for ser_tx_arbiter at GAP=0 and GAP=2, checked against a
// line-schedule model: each grant books its bits (and gap) into a queue.
module tb_ser_tx_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int ND = 2;
  localparam int QD = 64;

  typedef struct packed {
    logic          act;
    logic          sb;
    logic          lsb;
    logic [IW-1:0] gid;
  } slot_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pause = 1'b0;
  logic [N-1:0]   req        [ND];
  logic [N*W-1:0] data       [ND];
  logic [N-1:0]   ack        [ND];
  logic           serial_out [ND];
  logic           lsb_out    [ND];
  logic           active     [ND];
  logic [IW-1:0]  grant_id   [ND];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  slot_t        lq      [ND][QD];
  int           lq_n    [ND];
  int           ptr     [ND];
  slot_t        cur     [ND];
  logic [N-1:0] exp_ack [ND];
  int           gap_of  [ND] = '{0, 2};
  int           mode    = 2;   // 0 random, 1 hold req, 2 drop on ack only
  int           ack13   = 0;

  always #5 clk = ~clk;

  ser_tx_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .data(data[0]), .pause(pause),
    .ack(ack[0]), .serial_out(serial_out[0]), .lsb_out(lsb_out[0]),
    .active(active[0]), .grant_id(grant_id[0])
  );

  ser_tx_arbiter #(.WORD_SIZE(W), .NUM_REQ(N), .GAP(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req[1]), .data(data[1]), .pause(pause),
    .ack(ack[1]), .serial_out(serial_out[1]), .lsb_out(lsb_out[1]),
    .active(active[1]), .grant_id(grant_id[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Called right after a posedge with the inputs that edge sampled.
  task automatic model_edge();
    int win;
    logic [W-1:0] w;
    for (int d = 0; d < ND; d++) begin
      exp_ack[d] = '0;
      if (reset) begin
        lq_n[d] = 0;
        ptr[d]  = N - 1;
        cur[d]  = '0;
        continue;
      end
      if (lq_n[d] == 0 && !pause && req[d] != '0) begin
        win = -1;
        for (int k = 1; k <= N; k++)
          if (win < 0 && req[d][(ptr[d] + k) % N]) win = (ptr[d] + k) % N;
        ptr[d] = win;
        exp_ack[d][win] = 1'b1;
        w = data[d][win*W +: W];
        for (int b = 0; b < W; b++) begin
          lq[d][lq_n[d]] = '{act: 1'b1, sb: w[W-1-b], lsb: (b == W-1), gid: IW'(win)};
          lq_n[d]++;
        end
        for (int g = 0; g < gap_of[d]; g++) begin
          lq[d][lq_n[d]] = '0;
          lq_n[d]++;
        end
      end
      if (lq_n[d] > 0) begin
        cur[d] = lq[d][0];
        for (int s = 1; s < lq_n[d]; s++) lq[d][s-1] = lq[d][s];
        lq_n[d]--;
      end else begin
        cur[d] = '0;
      end
    end
  endtask

  task automatic check_outs();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("ack[d%0d]", d), 32'(ack[d]), 32'(exp_ack[d]));
      chk($sformatf("serial_out[d%0d]", d), 32'(serial_out[d]), 32'(cur[d].sb));
      chk($sformatf("lsb_out[d%0d]", d), 32'(lsb_out[d]), 32'(cur[d].lsb));
      chk($sformatf("active[d%0d]", d), 32'(active[d]), 32'(cur[d].act));
      if (cur[d].act || reset)
        chk($sformatf("grant_id[d%0d]", d), 32'(grant_id[d]), 32'(cur[d].gid));
      if (mode == 1) ack13 += int'(ack[d][1] | ack[d][3]);
    end
  endtask

  task automatic drive();
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++) begin
        if (exp_ack[d][i]) begin
          data[d][i*W +: W] = W'($urandom);   // captured word must be unaffected
          if (mode != 1) req[d][i] = 1'b0;
        end else if (mode == 0) begin
          if (!req[d][i]) begin
            if ($urandom_range(3) == 0) begin
              req[d][i] = 1'b1;
              data[d][i*W +: W] = W'($urandom);
            end
          end else if ($urandom_range(63) == 0) begin
            req[d][i] = 1'b0;
          end
        end
      end
    end
    if (mode == 0) begin
      if ($urandom_range(15) == 0) pause = ~pause;
      reset = ($urandom_range(299) == 0);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      model_edge();
      #1 check_outs();
      @(negedge clk);
      drive();
    end
  endtask

  task automatic set_req(input logic [N-1:0] r);
    for (int d = 0; d < ND; d++) req[d] = r;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      req[d]     = '0;
      data[d]    = '0;
      lq_n[d]    = 0;
      ptr[d]     = N - 1;
      cur[d]     = '0;
      exp_ack[d] = '0;
    end
    @(negedge clk);
    reset = 1'b1;
    step(3);
    reset = 1'b0;

    for (int d = 0; d < ND; d++) data[d][7:0] = 8'hA5;
    set_req(4'b0001);
    step(14);

    for (int d = 0; d < ND; d++) data[d] = 32'h4433_2211;
    set_req(4'b1111);
    step(44);

    mode = 1;
    ack13 = 0;
    set_req(4'b0101);
    step(60);
    chk("no_ack_req1_req3", 32'(ack13), 32'd0);

    mode = 2;
    set_req(4'b0000);
    step(12);

    for (int d = 0; d < ND; d++) data[d] = 32'h5A3C_96F0;
    set_req(4'b0001);
    step(4);
    pause = 1'b1;
    for (int d = 0; d < ND; d++) req[d][1] = 1'b1;
    step(16);
    pause = 1'b0;
    step(12);

    set_req(4'b0100);
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    set_req(4'b0110);
    step(24);

    mode = 0;
    pause = 1'b0;
    step(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
